// File: rtl/vga_pkg.sv
// Shared types for the VGA framebuffer: CPU control bundle, fill FSM states, store sizes.
// Also holds the store byte-enable and lane-alignment helpers. Pure types, no latency or backpressure.
package vga_pkg;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [1:0] size;
    } mem_ctrl_t;

    typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_B:    byte_en = 4'b0001 << lo;
            SZ_H:    byte_en = 4'b0011 << {lo[1], 1'b0};
            SZ_W:    byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

    // The CPU presents sub-word data in the low bits; replicate it so every enabled lane sees it.
    function automatic logic [31:0] store_align(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_B:    store_align = {4{wdata[7:0]}};
            SZ_H:    store_align = {2{wdata[15:0]}};
            default: store_align = wdata;
        endcase
    endfunction

endpackage

// File: rtl/vga_fb_engine_ram.sv
// Dual-port framebuffer RAM: port A byte-enabled read-before-write, port B read-only; 1-cycle reads.
// No backpressure; port B output holds while b_en is low.
module fb_dp_ram #(
    parameter int DEPTH = 1200,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [31:0]   a_wdata,
    output logic [31:0]   a_rdata,
    input  logic          b_en,
    input  logic [AW-1:0] b_addr,
    output logic [31:0]   b_rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        a_rdata <= mem[a_addr];
        for (int i = 0; i < 4; i++) begin
            if (a_we[i]) begin
                mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (b_en) begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/vga_fb_engine.sv
// Packed-pixel framebuffer with CPU byte-enabled port, 1-cycle readback, 2-cycle pixel reads, word-per-cycle fill.
// No backpressure: stores/loads are dropped or zeroed while a fill owns port A; pixel reads never stall.
module vga_fb_engine
    import vga_pkg::*;
#(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 60,
    parameter int BPP    = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [31:0]                i_addr,
    input  logic [31:0]                i_wdata,
    input  mem_ctrl_t                  i_ctrl,
    output logic [31:0]                o_rdata,
    output logic                       o_rvalid,
    input  logic                       i_fill_start,
    input  logic [BPP-1:0]             i_fill_color,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_wr_drop,
    input  logic                       i_pxl_en,
    input  logic [$clog2(WIDTH)-1:0]   i_pxlX,
    input  logic [$clog2(HEIGHT)-1:0]  i_pxlY,
    output logic [BPP-1:0]             o_value,
    output logic                       o_value_valid
);

    localparam int PPW   = 32 / BPP;
    localparam int WORDS = (WIDTH * HEIGHT + PPW - 1) / PPW;
    localparam int WA_W  = $clog2(WORDS);
    localparam int LW    = $clog2(PPW);

    if (!(BPP == 1 || BPP == 2 || BPP == 4 || BPP == 8)) begin : g_bad_bpp
        $error("vga_fb_engine: BPP must be 1, 2, 4 or 8");
    end

    fill_state_e      state;
    logic [WA_W-1:0]  cnt;
    logic [31:0]      pattern;
    logic             fill_act;

    logic [WA_W-1:0]  cpu_idx;
    logic             cpu_in_range;
    logic             cpu_wr_ok;
    logic             rd_ok;

    logic [3:0]       a_we;
    logic [WA_W-1:0]  a_addr;
    logic [31:0]      a_wdata;
    logic [31:0]      a_rdata;
    logic [31:0]      b_rdata;

    logic [31:0]      pix_n;
    logic             pix_oob;
    logic             s1_vld;
    logic [WA_W-1:0]  s1_word;
    logic [LW-1:0]    s1_lane;
    logic             s1_oob;
    logic [LW-1:0]    s2_lane;
    logic             s2_oob;
    logic             unused_bits;

    assign fill_act     = (state == FILL);
    assign cpu_idx      = i_addr[WA_W+1:2];
    assign cpu_in_range = (32'(cpu_idx) < WORDS);
    assign cpu_wr_ok    = i_ctrl.mem_write && cpu_in_range && !fill_act;
    assign unused_bits  = ^{i_addr[31:WA_W+2], pix_n[31:WA_W+LW]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_fill_start) begin
                        state   <= FILL;
                        cnt     <= '0;
                        pattern <= {PPW{i_fill_color}};
                        o_busy  <= 1'b1;
                    end
                end
                FILL: begin
                    if (cnt == WA_W'(WORDS - 1)) begin
                        state  <= DONE;
                        cnt    <= '0;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    o_done <= 1'b0;
                end
            endcase
        end
    end

    // Writes are gated during reset so an aborted fill never lands its in-flight word.
    always_comb begin
        a_we    = 4'b0000;
        a_addr  = cpu_idx;
        a_wdata = store_align(i_ctrl.size, i_wdata);
        if (fill_act) begin
            a_addr  = cnt;
            a_wdata = pattern;
            a_we    = 4'b1111;
        end else if (cpu_wr_ok) begin
            a_we = byte_en(i_ctrl.size, i_addr[1:0]);
        end
        if (i_rst) begin
            a_we = 4'b0000;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rvalid  <= 1'b0;
            rd_ok     <= 1'b0;
            o_wr_drop <= 1'b0;
        end else begin
            o_rvalid  <= i_ctrl.mem_read;
            rd_ok     <= i_ctrl.mem_read && cpu_in_range && !fill_act;
            o_wr_drop <= i_ctrl.mem_write && (!cpu_in_range || fill_act);
        end
    end

    assign o_rdata = rd_ok ? a_rdata : 32'h0;

    assign pix_n   = 32'(i_pxlY) * WIDTH + 32'(i_pxlX);
    assign pix_oob = (32'(i_pxlX) >= WIDTH) || (32'(i_pxlY) >= HEIGHT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_vld        <= 1'b0;
            s1_word       <= '0;
            s1_lane       <= '0;
            s1_oob        <= 1'b1;
            s2_lane       <= '0;
            s2_oob        <= 1'b1;
            o_value_valid <= 1'b0;
        end else begin
            s1_vld        <= i_pxl_en;
            o_value_valid <= s1_vld;
            if (i_pxl_en) begin
                s1_word <= pix_n[WA_W+LW-1:LW];
                s1_lane <= pix_n[LW-1:0];
                s1_oob  <= pix_oob;
            end
            if (s1_vld) begin
                s2_lane <= s1_lane;
                s2_oob  <= s1_oob;
            end
        end
    end

    // b_rdata, s2_lane and s2_oob only move on a valid beat, so o_value holds between requests.
    assign o_value = s2_oob ? '0 : b_rdata[s2_lane*BPP +: BPP];

    fb_dp_ram #(
        .DEPTH (WORDS),
        .AW    (WA_W)
    ) u_ram (
        .clk     (i_clk),
        .a_we    (a_we),
        .a_addr  (a_addr),
        .a_wdata (a_wdata),
        .a_rdata (a_rdata),
        .b_en    (s1_vld),
        .b_addr  (s1_word),
        .b_rdata (b_rdata)
    );

endmodule

// File: tb/tb_vga_fb_engine.sv
// Scoreboard bench for vga_fb_engine: default geometry plus a BPP=8, 64x32 instance.
module tb_vga_fb_engine;
    import vga_pkg::*;

    typedef struct {
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] addr, wdata;
    mem_ctrl_t   ctrl, ctrl8;
    logic        fill_start, fill_start8;
    logic [3:0]  color;
    logic [7:0]  color8;
    logic        pxl_en, pxl_en8;
    logic [7:0]  px_x;
    logic [5:0]  px_y;
    logic [5:0]  px8_x;
    logic [4:0]  px8_y;

    logic [31:0] rdata, rdata8;
    logic        rvalid, rvalid8, busy, busy8, done, done8, wr_drop, wr_drop8;
    logic [3:0]  value;
    logic [7:0]  value8;
    logic        value_valid, value_valid8;

    exp_t rd_q[$], px_q[$], rd8_q[$], px8_q[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    vga_fb_engine dut (
        .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_wdata(wdata), .i_ctrl(ctrl),
        .o_rdata(rdata), .o_rvalid(rvalid), .i_fill_start(fill_start), .i_fill_color(color),
        .o_busy(busy), .o_done(done), .o_wr_drop(wr_drop), .i_pxl_en(pxl_en),
        .i_pxlX(px_x), .i_pxlY(px_y), .o_value(value), .o_value_valid(value_valid)
    );

    vga_fb_engine #(.WIDTH(64), .HEIGHT(32), .BPP(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_wdata(wdata), .i_ctrl(ctrl8),
        .o_rdata(rdata8), .o_rvalid(rvalid8), .i_fill_start(fill_start8), .i_fill_color(color8),
        .o_busy(busy8), .o_done(done8), .o_wr_drop(wr_drop8), .i_pxl_en(pxl_en8),
        .i_pxlX(px8_x), .i_pxlY(px8_y), .o_value(value8), .o_value_valid(value_valid8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                         input logic exp_drop);
        tick();
        addr = a; wdata = d; ctrl.mem_write = 1'b1; ctrl.size = sz;
        tick();
        ctrl.mem_write = 1'b0;
        check("wr_drop", {31'b0, wr_drop}, {31'b0, exp_drop});
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] exp);
        tick();
        addr = a; ctrl.mem_read = 1'b1;
        rd_q.push_back('{dat: exp, cyc: cyc});
        tick();
        ctrl.mem_read = 1'b0;
    endtask

    task automatic load8(input logic [31:0] a, input logic [31:0] exp);
        tick();
        addr = a; ctrl8.mem_read = 1'b1;
        rd8_q.push_back('{dat: exp, cyc: cyc});
        tick();
        ctrl8.mem_read = 1'b0;
    endtask

    task automatic pix(input logic [7:0] x, input logic [5:0] y, input logic [3:0] exp);
        tick();
        px_x = x; px_y = y; pxl_en = 1'b1;
        px_q.push_back('{dat: {28'b0, exp}, cyc: cyc});
        tick();
        pxl_en = 1'b0;
    endtask

    task automatic pix8(input logic [5:0] x, input logic [4:0] y, input logic [7:0] exp);
        tick();
        px8_x = x; px8_y = y; pxl_en8 = 1'b1;
        px8_q.push_back('{dat: {24'b0, exp}, cyc: cyc});
        tick();
        pxl_en8 = 1'b0;
    endtask

    // act 1: store, load and a second start mid-fill; act 2: reset after 100 fill writes.
    task automatic fill_run(input logic [3:0] c, input int act, input int exp_busy);
        int n = 0;
        logic seen_done = 1'b0;
        tick();
        color = c; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        while (busy && n < 3000) begin
            if (act == 1 && n == 10) begin
                addr = 32'h8; wdata = 32'hDEADBEEF; ctrl.mem_write = 1'b1; ctrl.size = SZ_W;
                fill_start = 1'b1; color = 4'hF;
            end
            if (act == 1 && n == 11) begin
                ctrl.mem_write = 1'b0; fill_start = 1'b0;
                check("wr_drop_busy", {31'b0, wr_drop}, 32'd1);
                ctrl.mem_read = 1'b1;
                rd_q.push_back('{dat: 32'h0, cyc: cyc});
            end
            if (act == 1 && n == 12) ctrl.mem_read = 1'b0;
            if (act == 2 && n == 100) rst = 1'b1;
            tick();
            n++;
        end
        check("busy_cycles", n, exp_busy);
        if (act == 2) begin
            seen_done = done;
            tick();
            rst = 1'b0;
            repeat (5) begin
                tick();
                seen_done = seen_done | done | busy;
            end
            check("no_done_after_rst", {31'b0, seen_done}, 32'd0);
        end else begin
            check("done_pulse", {31'b0, done}, 32'd1);
            tick();
            check("done_clear", {31'b0, done}, 32'd0);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rvalid === 1'b1) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: got rvalid with rdata %h, expected none", rdata);
            end else begin
                e = rd_q.pop_front();
                check("rdata", rdata, e.dat);
                check("rd_latency", cyc - e.cyc, 32'd1);
            end
        end
        if (value_valid === 1'b1) begin
            if (px_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL px_unexpected: got value %h, expected none", value);
            end else begin
                e = px_q.pop_front();
                check("pixel", {28'b0, value}, e.dat);
                check("px_latency", cyc - e.cyc, 32'd2);
            end
        end
        if (rvalid8 === 1'b1) begin
            if (rd8_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd8_unexpected: got rdata %h, expected none", rdata8);
            end else begin
                e = rd8_q.pop_front();
                check("rdata8", rdata8, e.dat);
                check("rd8_latency", cyc - e.cyc, 32'd1);
            end
        end
        if (value_valid8 === 1'b1) begin
            if (px8_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL px8_unexpected: got value %h, expected none", value8);
            end else begin
                e = px8_q.pop_front();
                check("pixel8", {24'b0, value8}, e.dat);
                check("px8_latency", cyc - e.cyc, 32'd2);
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; addr = '0; wdata = '0; ctrl = '0; ctrl8 = '0;
        fill_start = 1'b0; fill_start8 = 1'b0; color = '0; color8 = '0;
        pxl_en = 1'b0; pxl_en8 = 1'b0; px_x = '0; px_y = '0; px8_x = '0; px8_y = '0;
        repeat (3) tick();
        check("rst_rdata", rdata, 32'h0);
        check("rst_flags", {22'b0, value, rvalid, value_valid, busy, done, wr_drop, 1'b0},
              32'h0);
        check("rst8_outs", {rdata8[23:0], value8}, 32'h0);
        check("rst8_flags", {27'b0, rvalid8, value_valid8, busy8, done8, wr_drop8}, 32'h0);
        rst = 1'b0;

        store(32'h0, 32'h76543210, SZ_W, 1'b0);
        for (int x = 0; x < 8; x++) pix(8'(x), 6'd0, 4'(x));

        store(32'h4, 32'hFFFFFFFF, SZ_W, 1'b0);
        store(32'h5, 32'h000000AB, SZ_B, 1'b0);
        load(32'h4, 32'hFFFFABFF);
        store(32'h6, 32'h00001234, SZ_H, 1'b0);
        load(32'h4, 32'h1234ABFF);
        tick();
        addr = 32'h4; wdata = 32'h0; ctrl = '{mem_read: 1'b1, mem_write: 1'b1, size: SZ_W};
        rd_q.push_back('{dat: 32'h1234ABFF, cyc: cyc});
        tick();
        ctrl = '0;
        load(32'h4, 32'h0);

        store(32'h12C0, 32'h11111111, SZ_W, 1'b1);
        load(32'h12C0, 32'h0);
        load(32'h1450, 32'h0);
        store(32'h50, 32'hFFFFFFFF, SZ_W, 1'b0);
        pix(8'd160, 6'd0, 4'h0);
        pix(8'd0, 6'd60, 4'h0);
        store(32'h0, 32'h0, 2'b11, 1'b0);
        load(32'h0, 32'h76543210);

        fill_run(4'h9, 1, 1200);
        for (int i = 0; i < 1200; i++) load(32'(i * 4), 32'h99999999);
        pix(8'd159, 6'd59, 4'h9);

        fill_run(4'h3, 2, 101);
        load(32'h0, 32'h33333333);
        load(32'(99 * 4), 32'h33333333);
        load(32'(100 * 4), 32'h99999999);
        load(32'(1199 * 4), 32'h99999999);

        fill_run(4'h6, 0, 1200);
        load(32'h0, 32'h66666666);
        load(32'(1199 * 4), 32'h66666666);
        pix(8'd159, 6'd59, 4'h6);

        tick();
        color8 = 8'h5A; fill_start8 = 1'b1;
        tick();
        fill_start8 = 1'b0;
        n = 0;
        while (busy8 && n < 3000) begin
            tick();
            n++;
        end
        check("busy8_cycles", n, 32'd512);
        check("done8_pulse", {31'b0, done8}, 32'd1);
        tick();
        check("done8_clear", {31'b0, done8}, 32'd0);
        load8(32'h0, 32'h5A5A5A5A);
        load8(32'(511 * 4), 32'h5A5A5A5A);
        pix8(6'd63, 5'd31, 8'h5A);
        pix8(6'd0, 5'd0, 8'h5A);

        n = 0;
        while ((rd_q.size() + px_q.size() + rd8_q.size() + px8_q.size()) != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain", 32'(rd_q.size() + px_q.size() + rd8_q.size() + px8_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_fb_engine.md
Name: vga_fb_engine

Overview:
Parametrised successor to the 4-bpp VGA framebuffer. Framebuffer geometry and pixel depth are configurable. The CPU gets a byte-enabled write port and a 1-cycle readback port. The block adds a hardware fill engine that clears or fills the whole buffer one word per cycle. It sits between the CPU memory-mapped VGA region and the VGA timing generator, and runs on a single clock; the timing generator supplies a pixel-enable strobe.

Parameters:
WIDTH, 160, pixels per line
HEIGHT, 60, lines
BPP, 4, bits per pixel; legal values 1, 2, 4, 8 (elaboration error otherwise)
Derived localparams (not overridable):
- PPW = 32/BPP, pixels per word
- WORDS = ceil(WIDTH*HEIGHT/PPW)
- WA_W = $clog2(WORDS)

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_addr  in  32  CPU byte address, offset within the VGA region
i_wdata  in  32  CPU store data
i_ctrl  in  mem_ctrl_t  memRead, memWrite, size (00 byte, 01 half, 10 word)
o_rdata  out  32  CPU read data
o_rvalid  out  1  o_rdata valid
i_fill_start  in  1  one-cycle pulse; start a fill
i_fill_color  in  BPP  colour to fill with
o_busy  out  1  fill in progress
o_done  out  1  one-cycle pulse when a fill completes
o_wr_drop  out  1  one-cycle pulse when a CPU store was discarded
i_pxl_en  in  1  pixel request strobe
i_pxlX  in  $clog2(WIDTH)  pixel column
i_pxlY  in  $clog2(HEIGHT)  pixel row
o_value  out  BPP  pixel colour
o_value_valid  out  1  o_value valid

Behaviour:
Storage and pixel packing
- Storage is fb_mem[WORDS] x 32, inferred as dual-port block RAM.
  - Port A: CPU and fill engine.
  - Port B: pixel read.
- Word index = i_addr[WA_W+1:2].
- Pixel n occupies word n/PPW, bits [(n%PPW)*BPP +: BPP]. Lowest pixel is in the low bits.
- n = Y*WIDTH + X.

CPU store
- Byte enables by size:
  - SB: 0001 << addr[1:0]
  - SH: 0011 << {addr[1],0}
  - SW: 1111
  - size 11: no write
- Write commits on the next rising edge.
- A store is discarded, with o_wr_drop asserted for 1 cycle, when either:
  - word index >= WORDS, or
  - o_busy = 1.

CPU load
- memRead in cycle t gives o_rvalid = 1 and o_rdata = full word in cycle t+1. The CPU performs byte extraction.
- Index out of range, or o_busy = 1: o_rdata = 0, o_rvalid still 1.
- Simultaneous memRead and memWrite to the same word: read returns the old data.

Pixel read
- Two-stage pipeline: i_pxl_en at t gives o_value_valid at t+2.
  - Stage 1 registers the word index and lane index.
  - Stage 2 registers the BRAM word and selects the lane.
- X >= WIDTH or Y >= HEIGHT: o_value = 0, valid still asserted.
- Pixel reads are never blocked. During a fill they return a mix of old and new contents.
- o_value holds its last value when not valid.

Fill FSM
- IDLE: i_fill_start goes to FILL. cnt = 0 and the colour is latched replicated PPW times into a 32-bit pattern.
- FILL: o_busy = 1. Write pattern to fb_mem[cnt] and increment cnt. When cnt == WORDS-1 (after that write), go to DONE.
  - A fill takes exactly WORDS cycles of writes.
- DONE: o_done = 1 for one cycle, then IDLE. o_busy = 0 in DONE.
- i_fill_start while in FILL or DONE is ignored. The colour change has no effect.
- i_fill_start and a CPU store in the same IDLE cycle: the store commits and the fill starts the next cycle.

Reset
- Outputs: o_rdata = 0, o_rvalid = 0, o_value = 0, o_value_valid = 0, o_busy = 0, o_done = 0, o_wr_drop = 0.
- FSM goes to IDLE, cnt = 0, pipeline valids cleared.
- fb_mem contents are NOT reset.
- Reset mid-fill aborts the fill. The partially filled words remain, and no o_done is issued.

Decomposition:
- Package vga_pkg:
  - mem_ctrl_t (shared with the memory system)
  - fill_state_e {IDLE, FILL, DONE}
  - size encoding constants SZ_B, SZ_H, SZ_W
- Sub-module fb_dp_ram:
  - parametrised depth, byte-enabled port A with read-before-write, read-only port B
  - keeps BRAM inference isolated
- Fill FSM, address decode and pixel pipeline live in the top level.

Test Plan:
- Pixel read: SW addr 0x0 data 0x76543210 (BPP 4) -> pixel reads X=0..7, Y=0 return 0..7, each with o_value_valid 2 cycles after i_pxl_en.
- Byte enables: SB addr 0x5 data 0xAB over word 0xFFFFFFFF at index 1 -> readback of addr 0x4 = 0xFFFFABFF at t+1. SH addr 0x6 data 0x1234 -> 0x1234ABFF.
- Fill timing: fill_start, colour 0x9 (defaults) -> o_busy high for exactly 1200 cycles, then o_done pulse. Every word reads 0x99999999 and pixel (159,59) = 0x9.
- Busy interactions: SW during FILL -> o_wr_drop pulse, word overwritten by fill. Load during FILL -> rdata 0, rvalid 1. Second fill_start mid-fill -> ignored, still 1200 cycles total.
- Out of range: SW to word 1200 -> o_wr_drop, no memory change. Pixel X=160 -> o_value 0. Load of word 1300 -> 0.
- Reset mid-fill: assert i_rst at fill cycle 100 -> o_busy 0 and no o_done. Words 0..99 hold the fill colour, words >= 100 are unchanged. A new fill then completes normally. Repeat the fill test with BPP=8, WIDTH=64, HEIGHT=32 -> 512 cycles, colour 0x5A gives 0x5A5A5A5A.
